decode_stage: RTL
=================

# decode_stage

Decode stage directly upstream of the registered ALU in the RV64I integer pipe. It accepts one 32-bit instruction and its PC per handshake, reads the register file, and applies optional operand forwarding. It produces the operand/control bundle the ALU consumes: `imm`, `op1`, `op2`, `funct3`, `funct7`, plus `rd` and an `illegal` flag. Output is registered behind a 2-entry skid buffer, so `in_ready` is a pure flop output.

## Interface
Parameters:
- `XLEN`, 64, datapath width; only 64 is supported.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  stage can accept; registered.
- `in_inst`  in  32  instruction word.
- `in_pc`  in  64  instruction PC.
- `rf_rs1`, `rf_rs2`  out  5 each  register-file read addresses; combinational from `in_inst[19:15]` and `in_inst[24:20]`.
- `rf_rdata1`, `rf_rdata2`  in  64 each  combinational read data, same cycle.
- `fwd_valid`  in  1  writeback source valid.
- `fwd_rd`  in  5  writeback destination.
- `fwd_data`  in  64  writeback value.
- `out_valid`  out  1  bundle valid.
- `out_ready`  in  1  ALU accepts.
- `imm`  out  1  ALU immediate flag.
- `op1`, `op2`  out  64 each  ALU operands.
- `funct3`  out  3  ALU function select.
- `funct7`  out  7  ALU function modifier.
- `rd`  out  5  destination register.
- `illegal`  out  1  unsupported encoding.

## Operation
- Accept on `in_valid && in_ready` at a rising edge. Decode is combinational from `in_inst`, `in_pc`, `rf_rdata*` and `fwd_*`, and is captured at the accept edge.
- Register x0 always reads 0, regardless of `rf_rdata*`.
- **OP (0110011)**
  - `imm`=0, `op1`=rs1 value, `op2`=rs2 value, `funct7`=`inst[31:25]`.
  - `funct7` other than 0000000 or 0100000 → illegal.
- **OP-IMM (0010011)**
  - `imm`=1, `op1`=rs1 value, `op2`=sign-extended `inst[31:20]`, `funct7`=0.
  - Exception for funct3 001/101: `op2`={58'b0, `inst[25:20]`} and `funct7`={`inst[31:26]`,1'b0}.
- **LUI (0110111)**: `imm`=1, `op1`=0, `op2`=sign-extended {`inst[31:12]`,12'b0}, `funct3`=000, `funct7`=0.
- **AUIPC (0010111)**: same as LUI, but `op1`=`in_pc`.
- **Any other opcode**: `illegal`=1; `op1`, `op2`, `funct3`, `funct7` and `rd` are all 0. The bundle still flows, so downstream can trap.
- Otherwise `funct3`=`inst[14:12]` and `rd`=`inst[11:7]`.
- Skid buffer has two entries:
  - `main` drives the outputs; `skid` holds the overflow entry.
  - Accept while `main` is empty, or while `main` is being drained (`out_ready`): the entry goes to `main`.
  - Accept while `main` is valid and stalled: the entry goes to `skid`, and `in_ready` falls the next cycle.
  - When `skid` is valid and `out_ready` is high: `skid` moves to `main` and `in_ready` rises the next cycle.
- `in_ready` = !`skid_valid` (registered).
- Output bundle is held stable while `out_valid && !out_ready`.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0.
  - `imm`, `op1`, `op2`, `funct3`, `funct7`, `rd`, `illegal` = 0.
  - Skid buffer empty.
- Reset mid-operation discards both entries immediately (asynchronous).
- Latency: accept at edge N → `out_valid` high after edge N.
- Throughput: 1 instruction per cycle with `out_ready` held high.
- Full condition: two entries held, `in_ready`=0. Accept and drain in the same cycle keeps occupancy unchanged.
- Forwarding sampled at the accept edge only. Entries already buffered are not re-forwarded; downstream hazard logic owns that.

## Configuration
- `DECODE_FWD_EN` defined:
  - If `fwd_valid && fwd_rd != 0 && fwd_rd == rs1`, rs1 value = `fwd_data`; same for rs2.
  - Forwarding takes priority over `rf_rdata*`.
- Undefined: `fwd_*` ports exist but are ignored; operands come only from `rf_rdata*`.

## Structure
- Shared package `decode_defs` holds:
  - Opcode constants: OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC.
  - funct7 constants: F7_BASE, F7_ALT.
  - The packed bundle layout {illegal, rd, funct7, funct3, op2, op1, imm}, used for both buffer entries.
- One sub-module, `imm_gen`: instruction in → 64-bit `op2` immediate plus the shamt/`funct7` fix-up for shifts.

## Test plan
- **Reset**: assert `RST`. Required: `in_ready`=1, `out_valid`=0, all data outputs 0.
- **addi x1,x2,-5** (0xFFB10093), x2=10. Required next cycle: `imm`=1, `op1`=10, `op2`=0xFFFFFFFFFFFFFFFB, `funct3`=000, `rd`=1.
- **sub x3,x1,x2** (0x402081B3) and **slli x5,x6,33** (0x02131293):
  - sub: `funct7`=0100000, `imm`=0.
  - slli: `op2`=33, `funct7`=0000000, `funct3`=001.
- **lui x7,0x80000** (0x800003B7): `op1`=0, `op2`=0xFFFFFFFF80000000. Opcode 0x0000007F: `illegal`=1, `rd`=0.
- **Backpressure**: hold `out_ready`=0 and send 3 back-to-back instructions.
  - Required: two are held and `in_ready`=0 after the 2nd accept.
  - Release `out_ready`: both are delivered in order with no loss or duplication.
- **DECODE_FWD_EN**: `fwd_valid`=1, `fwd_rd`=2, `fwd_data`=0x1234, `rf_rdata1`=10, rs1=2. Required: `op1`=0x1234.
  - With `fwd_rd`=0: `op1`=10.
  - Macro undefined: `op1`=10.

Source files
------------

// File: rtl/decode_defs.sv
// Shared definitions for the RV64I decode stage: opcode and funct7 constants,
// and the packed operand/control bundle held in both skid-buffer entries.
package decode_defs;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  // Bundle handed to the ALU; field order is {illegal, rd, funct7, funct3, op2, op1, imm}.
  typedef struct packed {
    logic        illegal;
    logic [4:0]  rd;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [63:0] op2;
    logic [63:0] op1;
    logic        imm;
  } bundle_t;

  // Immediate shifts carry a 6-bit shamt instead of a 12-bit immediate.
  function automatic logic is_shift_imm(input logic [2:0] funct3);
    return (funct3 == F3_SLL) || (funct3 == F3_SRX);
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: produces the 64-bit immediate operand and the funct7
// value the ALU sees, including the shamt/funct7 fix-up for OP-IMM shifts.
module imm_gen
  import decode_defs::*;
(
  input  logic [31:0] i_inst,
  output logic [63:0] o_imm,
  output logic [6:0]  o_funct7
);

  // The destination field plays no part in immediate formation.
  logic w_unused_rd;
  assign w_unused_rd = ^i_inst[11:7];

  // Select immediate format and funct7 from the opcode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    o_imm    = '0;
    o_funct7 = '0;
    case (i_inst[6:0])
      OPC_OP: begin
        o_funct7 = i_inst[31:25];
      end
      OPC_OPIMM: begin
        if (is_shift_imm(i_inst[14:12])) begin
          // inst[25] is the top shamt bit on RV64, so funct7 keeps only [31:26].
          o_imm    = {58'b0, i_inst[25:20]};
          o_funct7 = {i_inst[31:26], 1'b0};
        end else begin
          o_imm    = {{52{i_inst[31]}}, i_inst[31:20]};
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        o_imm = {{32{i_inst[31]}}, i_inst[31:12], 12'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV64I decode stage feeding the registered ALU. Decodes one instruction per
// handshake, reads the register file, optionally forwards the writeback value,
// and registers the result behind a 2-entry skid buffer (main + skid).
// Optional feature: DECODE_FWD_EN enables writeback-to-operand forwarding.
module decode_stage
  import decode_defs::*;
#(
  parameter int XLEN = 64
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            imm,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic            illegal
);

  bundle_t         r_main;
  bundle_t         r_skid;
  logic            r_main_valid;
  logic            r_skid_valid;
  logic            r_in_ready;

  bundle_t         w_bundle;
  bundle_t         w_main_nxt;
  bundle_t         w_skid_nxt;
  logic            w_main_valid_nxt;
  logic            w_skid_valid_nxt;
  logic            w_accept;
  logic [63:0]     w_imm_val;
  logic [6:0]      w_imm_funct7;
  logic [XLEN-1:0] w_rs1_raw;
  logic [XLEN-1:0] w_rs2_raw;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;

  assign rf_rs1 = in_inst[19:15];
  assign rf_rs2 = in_inst[24:20];

`ifdef DECODE_FWD_EN
  // Writeback data overrides the register file when it targets the source register.
  assign w_rs1_raw = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == rf_rs1) ? fwd_data : rf_rdata1;
  assign w_rs2_raw = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == rf_rs2) ? fwd_data : rf_rdata2;
`else
  assign w_rs1_raw = rf_rdata1;
  assign w_rs2_raw = rf_rdata2;
  logic w_unused_fwd;
  assign w_unused_fwd = ^{fwd_valid, fwd_rd, fwd_data};
`endif

  // x0 is hardwired to zero whatever the register file returns.
  assign w_rs1_val = (rf_rs1 == 5'd0) ? '0 : w_rs1_raw;
  assign w_rs2_val = (rf_rs2 == 5'd0) ? '0 : w_rs2_raw;

  imm_gen u_imm_gen (
    .i_inst   (in_inst),
    .o_imm    (w_imm_val),
    .o_funct7 (w_imm_funct7)
  );

  // Build the ALU bundle for the instruction currently presented.
  always_comb begin
    w_bundle = '0;
    case (in_inst[6:0])
      OPC_OP: begin
        w_bundle.op1     = w_rs1_val;
        w_bundle.op2     = w_rs2_val;
        w_bundle.funct7  = w_imm_funct7;
        w_bundle.funct3  = in_inst[14:12];
        w_bundle.rd      = in_inst[11:7];
        w_bundle.illegal = (w_imm_funct7 != F7_BASE) && (w_imm_funct7 != F7_ALT);
      end
      OPC_OPIMM: begin
        w_bundle.imm    = 1'b1;
        w_bundle.op1    = w_rs1_val;
        w_bundle.op2    = w_imm_val;
        w_bundle.funct7 = w_imm_funct7;
        w_bundle.funct3 = in_inst[14:12];
        w_bundle.rd     = in_inst[11:7];
      end
      OPC_LUI: begin
        w_bundle.imm = 1'b1;
        w_bundle.op2 = w_imm_val;
        w_bundle.rd  = in_inst[11:7];
      end
      OPC_AUIPC: begin
        w_bundle.imm = 1'b1;
        w_bundle.op1 = in_pc;
        w_bundle.op2 = w_imm_val;
        w_bundle.rd  = in_inst[11:7];
      end
      default: begin
        // Unknown opcodes still flow so downstream can raise the trap.
        w_bundle.illegal = 1'b1;
      end
    endcase
  end

  assign w_accept = in_valid && r_in_ready;

  // Skid buffer next-state: fill main when it is free or draining, else spill to skid.
  always_comb begin
    w_main_nxt       = r_main;
    w_main_valid_nxt = r_main_valid;
    w_skid_nxt       = r_skid;
    w_skid_valid_nxt = r_skid_valid;
    if (!r_main_valid || out_ready) begin
      if (r_skid_valid) begin
        // in_ready is low whenever skid is occupied, so no accept can coincide here.
        w_main_nxt       = r_skid;
        w_main_valid_nxt = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end else if (w_accept) begin
        w_main_nxt       = w_bundle;
        w_main_valid_nxt = 1'b1;
      end else begin
        w_main_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      w_skid_nxt       = w_bundle;
      w_skid_valid_nxt = 1'b1;
    end
  end

  // Buffer state and the registered ready flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: both entries' data are reset as well as their valid bits, because main drives the outputs and they must read zero out of reset.
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples the pre-edge values.
      r_main       <= w_main_nxt;
      r_skid       <= w_skid_nxt;
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_valid;
  assign imm       = r_main.imm;
  assign op1       = r_main.op1;
  assign op2       = r_main.op2;
  assign funct3    = r_main.funct3;
  assign funct7    = r_main.funct7;
  assign rd        = r_main.rd;
  assign illegal   = r_main.illegal;

endmodule
